// File: rtl/mips_pkg.sv
// Shared constants and helpers for the MIPS front-end pipeline stages.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    // sll $0,$0,0 encodes as all zeros
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam int          WORD_BYTES       = 4;

    // Instruction addresses are always word aligned; drop the byte offset.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures the fetched instruction and its PC+4 for decode.
// Latency: 1 cycle from load inputs to outputs.
// Backpressure: hold freezes contents; squash (redirect/flush) overrides hold and inserts a bubble.
module if_id_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        squash,
    input  logic        hold,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc_plus4,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    // Priority: reset, then squash to a bubble, then hold, then load the new fetch.
    always_ff @(posedge clk) begin
        if (reset || squash) begin
            instr    <= NOP_WORD;
            pc_plus4 <= 32'd0;
            valid    <= 1'b0;
        end else if (!hold) begin
            instr    <= load_instr;
            pc_plus4 <= load_pc_plus4;
            valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection and IF/ID register for decode.
// Latency: instruction memory is combinational, so a fetch reaches IF/ID one cycle after the PC.
// Backpressure: stall holds PC and IF/ID; a redirect overrides stall and squashes the wrong-path fetch.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid
);

    logic [31:0] pc_plus4;
    logic        redirect;
    logic [31:0] redirect_target;

    // Sequential PC wraps silently at the top of the address space.
    assign pc_plus4  = pc + 32'(WORD_BYTES);
    assign imem_addr = pc;

    // Jump wins over a simultaneous taken branch.
    assign redirect        = jump | branch_taken;
    assign redirect_target = jump ? align_word(jump_target) : align_word(branch_target);

    // PC register: reset, redirect, then advance unless stalled (flush does not affect the PC).
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_target;
        end else if (!stall) begin
            pc <= pc_plus4;
        end
    end

    if_id_reg #(
        .NOP_WORD (NOP_INSTR)
    ) u_if_id_reg (
        .clk           (clk),
        .reset         (reset),
        .squash        (redirect | flush),
        .hold          (stall),
        .load_instr    (imem_instr),
        .load_pc_plus4 (pc_plus4),
        .instr         (if_id_instr),
        .pc_plus4      (if_id_pc_plus4),
        .valid         (if_id_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage with a behavioural instruction ROM.
// Latency: expectations are compared one clock after the stimulus that produces them.
// Backpressure: exercises stall, flush, branch/jump redirects, reset and PC wrap.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;

    logic [31:0] rom [256];

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic        rst;
        logic        stl;
        logic        fls;
        logic        br;
        logic [31:0] bt;
        logic        j;
        logic [31:0] jt;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } step_t;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } exp_t;

    exp_t exp_q [$];

    always #5 clk = ~clk;

    assign imem_instr = rom[imem_addr[9:2]];

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .pc             (pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid)
    );

    function automatic logic [31:0] rv(input int i);
        return 32'h2400_0000 | 32'(i);
    endfunction

    function automatic step_t mk(input string tag, input logic rst, input logic stl, input logic fls,
                                 input logic br, input logic [31:0] bt, input logic j, input logic [31:0] jt,
                                 input logic [31:0] epc, input logic [31:0] ein, input logic [31:0] ep4,
                                 input logic ev);
        step_t s;
        s.tag = tag; s.rst = rst; s.stl = stl; s.fls = fls; s.br = br; s.bt = bt;
        s.j = j; s.jt = jt; s.pc = epc; s.instr = ein; s.pc4 = ep4; s.valid = ev;
        return s;
    endfunction

    // Drive one cycle of stimulus and queue the state it must produce at the next edge.
    task automatic drive(input step_t s);
        exp_t e;
        reset = s.rst; stall = s.stl; flush = s.fls;
        branch_taken = s.br; branch_target = s.bt; jump = s.j; jump_target = s.jt;
        e.tag = s.tag; e.pc = s.pc; e.instr = s.instr; e.pc4 = s.pc4; e.valid = s.valid;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step_t s [$];
        exp_t  e;
        s.push_back(mk("reset", 1, 0, 0, 0, 0, 0, 0, 32'h0, NOP, 32'h0, 0));
        foreach (s[i]) begin
            drive(s[i]);
            e = exp_q.pop_front();
            checks += 5;
            if (pc !== e.pc) begin errors++; $display("FAIL %s pc: got %h expected %h", e.tag, pc, e.pc); end
            if (imem_addr !== e.pc) begin errors++; $display("FAIL %s imem_addr: got %h expected %h", e.tag, imem_addr, e.pc); end
            if (if_id_instr !== e.instr) begin errors++; $display("FAIL %s instr: got %h expected %h", e.tag, if_id_instr, e.instr); end
            if (if_id_pc_plus4 !== e.pc4) begin errors++; $display("FAIL %s pc_plus4: got %h expected %h", e.tag, if_id_pc_plus4, e.pc4); end
            if (if_id_valid !== e.valid) begin errors++; $display("FAIL %s valid: got %b expected %b", e.tag, if_id_valid, e.valid); end
        end
    endtask

    task automatic test_sequential();
        step_t s [$];
        exp_t  e;
        s.push_back(mk("seq0", 0, 0, 0, 0, 0, 0, 0, 32'h4, rv(0), 32'h4, 1));
        s.push_back(mk("seq1", 0, 0, 0, 0, 0, 0, 0, 32'h8, rv(1), 32'h8, 1));
        foreach (s[i]) begin
            drive(s[i]);
            e = exp_q.pop_front();
            checks += 5;
            if (pc !== e.pc) begin errors++; $display("FAIL %s pc: got %h expected %h", e.tag, pc, e.pc); end
            if (imem_addr !== e.pc) begin errors++; $display("FAIL %s imem_addr: got %h expected %h", e.tag, imem_addr, e.pc); end
            if (if_id_instr !== e.instr) begin errors++; $display("FAIL %s instr: got %h expected %h", e.tag, if_id_instr, e.instr); end
            if (if_id_pc_plus4 !== e.pc4) begin errors++; $display("FAIL %s pc_plus4: got %h expected %h", e.tag, if_id_pc_plus4, e.pc4); end
            if (if_id_valid !== e.valid) begin errors++; $display("FAIL %s valid: got %b expected %b", e.tag, if_id_valid, e.valid); end
        end
    endtask

    task automatic test_stall();
        step_t s [$];
        exp_t  e;
        s.push_back(mk("stall0",    0, 1, 0, 0, 0, 0, 0, 32'h8, rv(1), 32'h8, 1));
        s.push_back(mk("stall1",    0, 1, 0, 0, 0, 0, 0, 32'h8, rv(1), 32'h8, 1));
        s.push_back(mk("stall_rel", 0, 0, 0, 0, 0, 0, 0, 32'hC, rv(2), 32'hC, 1));
        foreach (s[i]) begin
            drive(s[i]);
            e = exp_q.pop_front();
            checks += 4;
            if (pc !== e.pc) begin errors++; $display("FAIL %s pc: got %h expected %h", e.tag, pc, e.pc); end
            if (if_id_instr !== e.instr) begin errors++; $display("FAIL %s instr: got %h expected %h", e.tag, if_id_instr, e.instr); end
            if (if_id_pc_plus4 !== e.pc4) begin errors++; $display("FAIL %s pc_plus4: got %h expected %h", e.tag, if_id_pc_plus4, e.pc4); end
            if (if_id_valid !== e.valid) begin errors++; $display("FAIL %s valid: got %b expected %b", e.tag, if_id_valid, e.valid); end
        end
    endtask

    task automatic test_flush();
        step_t s [$];
        exp_t  e;
        s.push_back(mk("flush",       0, 0, 1, 0, 0, 1'b0, 0,     32'h10, NOP,   32'h0,  0));
        s.push_back(mk("jmp_c",       0, 0, 0, 0, 0, 1'b1, 32'hC, 32'hC,  NOP,   32'h0,  0));
        s.push_back(mk("flush_stall", 0, 1, 1, 0, 0, 1'b0, 0,     32'hC,  NOP,   32'h0,  0));
        s.push_back(mk("after_flush", 0, 0, 0, 0, 0, 1'b0, 0,     32'h10, rv(3), 32'h10, 1));
        foreach (s[i]) begin
            drive(s[i]);
            e = exp_q.pop_front();
            checks += 4;
            if (pc !== e.pc) begin errors++; $display("FAIL %s pc: got %h expected %h", e.tag, pc, e.pc); end
            if (if_id_instr !== e.instr) begin errors++; $display("FAIL %s instr: got %h expected %h", e.tag, if_id_instr, e.instr); end
            if (if_id_pc_plus4 !== e.pc4) begin errors++; $display("FAIL %s pc_plus4: got %h expected %h", e.tag, if_id_pc_plus4, e.pc4); end
            if (if_id_valid !== e.valid) begin errors++; $display("FAIL %s valid: got %b expected %b", e.tag, if_id_valid, e.valid); end
        end
    endtask

    task automatic test_branch();
        step_t s [$];
        exp_t  e;
        s.push_back(mk("branch",   0, 0, 0, 1, 32'h23, 0, 0, 32'h20, NOP,   32'h0,  0));
        s.push_back(mk("after_br", 0, 0, 0, 0, 32'h0,  0, 0, 32'h24, rv(8), 32'h24, 1));
        foreach (s[i]) begin
            drive(s[i]);
            e = exp_q.pop_front();
            checks += 4;
            if (pc !== e.pc) begin errors++; $display("FAIL %s pc: got %h expected %h", e.tag, pc, e.pc); end
            if (if_id_instr !== e.instr) begin errors++; $display("FAIL %s instr: got %h expected %h", e.tag, if_id_instr, e.instr); end
            if (if_id_pc_plus4 !== e.pc4) begin errors++; $display("FAIL %s pc_plus4: got %h expected %h", e.tag, if_id_pc_plus4, e.pc4); end
            if (if_id_valid !== e.valid) begin errors++; $display("FAIL %s valid: got %b expected %b", e.tag, if_id_valid, e.valid); end
        end
    endtask

    task automatic test_jump_priority();
        step_t s [$];
        exp_t  e;
        s.push_back(mk("jmp_prio",  0, 1, 0, 1, 32'h80, 1, 32'h40, 32'h40, NOP,      32'h0,  0));
        s.push_back(mk("after_jmp", 0, 0, 0, 0, 32'h0,  0, 32'h0,  32'h44, rv(16),   32'h44, 1));
        foreach (s[i]) begin
            drive(s[i]);
            e = exp_q.pop_front();
            checks += 4;
            if (pc !== e.pc) begin errors++; $display("FAIL %s pc: got %h expected %h", e.tag, pc, e.pc); end
            if (if_id_instr !== e.instr) begin errors++; $display("FAIL %s instr: got %h expected %h", e.tag, if_id_instr, e.instr); end
            if (if_id_pc_plus4 !== e.pc4) begin errors++; $display("FAIL %s pc_plus4: got %h expected %h", e.tag, if_id_pc_plus4, e.pc4); end
            if (if_id_valid !== e.valid) begin errors++; $display("FAIL %s valid: got %b expected %b", e.tag, if_id_valid, e.valid); end
        end
    endtask

    task automatic test_reset_mid_jump();
        step_t s [$];
        exp_t  e;
        s.push_back(mk("jmp_40",    0, 0, 0, 0, 0, 1, 32'h40, 32'h40, NOP,   32'h0, 0));
        s.push_back(mk("rst_jmp",   1, 1, 0, 0, 0, 1, 32'h40, 32'h0,  NOP,   32'h0, 0));
        s.push_back(mk("after_rst", 0, 0, 0, 0, 0, 0, 32'h0,  32'h4,  rv(0), 32'h4, 1));
        foreach (s[i]) begin
            drive(s[i]);
            e = exp_q.pop_front();
            checks += 4;
            if (pc !== e.pc) begin errors++; $display("FAIL %s pc: got %h expected %h", e.tag, pc, e.pc); end
            if (if_id_instr !== e.instr) begin errors++; $display("FAIL %s instr: got %h expected %h", e.tag, if_id_instr, e.instr); end
            if (if_id_pc_plus4 !== e.pc4) begin errors++; $display("FAIL %s pc_plus4: got %h expected %h", e.tag, if_id_pc_plus4, e.pc4); end
            if (if_id_valid !== e.valid) begin errors++; $display("FAIL %s valid: got %b expected %b", e.tag, if_id_valid, e.valid); end
        end
    endtask

    task automatic test_wrap_alias();
        step_t s [$];
        exp_t  e;
        s.push_back(mk("jmp_top",   0, 0, 0, 0, 0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, NOP,     32'h0,   0));
        s.push_back(mk("wrap",      0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         rv(255), 32'h0,   1));
        s.push_back(mk("alias_jmp", 0, 0, 0, 0, 0, 1, 32'h401,       32'h400,       NOP,     32'h0,   0));
        s.push_back(mk("alias",     0, 0, 0, 0, 0, 0, 32'h0,         32'h404,       rv(0),   32'h404, 1));
        foreach (s[i]) begin
            drive(s[i]);
            e = exp_q.pop_front();
            checks += 5;
            if (pc !== e.pc) begin errors++; $display("FAIL %s pc: got %h expected %h", e.tag, pc, e.pc); end
            if (imem_addr !== e.pc) begin errors++; $display("FAIL %s imem_addr: got %h expected %h", e.tag, imem_addr, e.pc); end
            if (if_id_instr !== e.instr) begin errors++; $display("FAIL %s instr: got %h expected %h", e.tag, if_id_instr, e.instr); end
            if (if_id_pc_plus4 !== e.pc4) begin errors++; $display("FAIL %s pc_plus4: got %h expected %h", e.tag, if_id_pc_plus4, e.pc4); end
            if (if_id_valid !== e.valid) begin errors++; $display("FAIL %s valid: got %b expected %b", e.tag, if_id_valid, e.valid); end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = rv(i);
        #2;
        test_reset();
        test_sequential();
        test_stall();
        test_flush();
        test_branch();
        test_jump_priority();
        test_reset_mid_jump();
        test_wrap_alias();
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
